relu_rowpair: RTL and testbench
===============================

RELU_ROWPAIR -- requirements
Module: relu_rowpair

Interface
REQ-001 Parameter BD, default 18, data bit width per channel (two's complement).
REQ-002 Parameter WIDTH, default 28, pixels per row.
REQ-003 Parameter ROWS, default 28, rows per frame; even.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 start  input  1  frame start pulse; honoured only in IDLE or DONE.
REQ-007 vin  input  1  upstream pixel valid.
REQ-008 din_c0, din_c1, din_c2  input  BD each  upstream pixel, channels 0..2, signed.
REQ-009 pool_busy  input  1  pooling stage active flag (its read-enable level).
REQ-010 stall  output  1  backpressure; upstream SHALL NOT drive vin while high.
REQ-011 wren0  output  1  write enable, even-row bank.
REQ-012 wren1  output  1  write enable, odd-row bank.
REQ-013 wraddr  output  11  write address, shared by both banks.
REQ-014 wd_c0, wd_c1, wd_c2  output  BD each  ReLU-ed write data.
REQ-015 ready_out  output  1  row pair complete, consumed by pooling stage edge detector.
REQ-016 frame_done  output  1  one-cycle pulse, frame finished.
REQ-017 ovf  output  1  sticky error: vin seen while stall high.

Function
REQ-018 States SHALL be IDLE, ROW0, ROW1, HANDOFF, WAIT, DONE.
REQ-019 IDLE -> ROW0 on start; col=0, pair=0, stall=0.
REQ-020 In ROW0/ROW1, each cycle with vin=1 SHALL accept one pixel at column col, then col increments; col==WIDTH-1 accepted -> col=0.
REQ-021 ROW0 last column accepted -> ROW1; ROW1 last column accepted -> HANDOFF.
REQ-022 Write latency SHALL be 1 cycle: pixel accepted at edge N -> wren0 (ROW0) or wren1 (ROW1) high, wraddr=col, wd valid during cycle after edge N; exactly one of wren0/wren1 high per accepted pixel, both low otherwise.
REQ-023 ReLU per channel: sign bit 1 -> 0; else passthrough unchanged, full BD bits.
REQ-024 HANDOFF: stall=1; ready_out SHALL rise the cycle after the final wren1 cycle and stay high exactly 2 cycles; then -> WAIT.
REQ-025 WAIT: stall=1; seen_busy flag set on pool_busy=1; leave WAIT on first cycle with seen_busy=1 and pool_busy=0; seen_busy cleared on exit.
REQ-026 On WAIT exit pair increments; pair==ROWS/2 -> DONE with frame_done pulse that cycle; else -> ROW0, stall=0.
REQ-027 pool_busy already high on HANDOFF entry SHALL count as seen; pool_busy high in ROW0/ROW1 ignored.
REQ-028 DONE: stall=1; start -> ROW0 with col=0, pair=0; start elsewhere ignored (including mid-frame).
REQ-029 vin in IDLE, HANDOFF, WAIT, DONE: pixel discarded, no write, ovf set; ovf cleared only by reset.
REQ-030 vin and state-changing last-column accept on same edge: that pixel written, transition taken same edge.
REQ-031 stall SHALL be combinationally low only in ROW0/ROW1, high in all other states.

Reset
REQ-032 reset high: state IDLE, col=0, pair=0, seen_busy=0; outputs stall=1, wren0=0, wren1=0, wraddr=0, wd_c*=0, ready_out=0, frame_done=0, ovf=0.
REQ-033 reset asserted mid-row or mid-handoff SHALL abort immediately; no further writes, ready_out dropped; resume only via start after release.

Verification
REQ-034 start, 28 pixels din_c0=5..32 -> wren0 at wraddr 0..27, wd_c0=5..32, wren1 never high.
REQ-035 din_c1=-3 (all ones upper bits), din_c2=0x1FFFF -> wd_c1=0, wd_c2=0x1FFFF.
REQ-036 56 back-to-back pixels -> ready_out high exactly 2 cycles starting 1 cycle after last wren1 at wraddr 27; stall=1 from accept of pixel 56.
REQ-037 pool_busy pulse 0->1 (30 cycles)->0 -> stall drops 1 cycle after pool_busy falls; next pixel to wren0 wraddr 0.
REQ-038 full 28x28 frame with pool handshakes -> 14 ready_out pulses, frame_done single pulse after 14th pool_busy fall, state DONE.
REQ-039 vin during WAIT -> no wren, ovf=1 held; reset at column 10 of ROW1 -> all outputs per REQ-032 same cycle.

Source files
------------

// File: rtl/relu_rowpair_if.sv
// Bus between the upstream pixel source, the row-pair line buffer writer and
// the pooling stage. The writer (relu_rowpair) connects through the slave
// modport; the pixel source / pooling side connects through master.
//
// Pixel handshake: a pixel transfers on a rising clk edge where vin=1 and
// stall=0. vin seen while stall=1 is dropped and latches the sticky ovf flag.
interface relu_rowpair_if #(
    parameter int BD = 18
);
    logic                 start;
    logic                 vin;
    logic signed [BD-1:0] din_c0;
    logic signed [BD-1:0] din_c1;
    logic signed [BD-1:0] din_c2;
    logic                 pool_busy;
    logic                 stall;
    logic                 wren0;
    logic                 wren1;
    logic [10:0]          wraddr;
    logic [BD-1:0]        wd_c0;
    logic [BD-1:0]        wd_c1;
    logic [BD-1:0]        wd_c2;
    logic                 ready_out;
    logic                 frame_done;
    logic                 ovf;
    logic [2:0]           dbg_state;

    modport slave (
        input  start, vin, din_c0, din_c1, din_c2, pool_busy,
        output stall, wren0, wren1, wraddr, wd_c0, wd_c1, wd_c2,
               ready_out, frame_done, ovf, dbg_state
    );

    modport master (
        output start, vin, din_c0, din_c1, din_c2, pool_busy,
        input  stall, wren0, wren1, wraddr, wd_c0, wd_c1, wd_c2,
               ready_out, frame_done, ovf, dbg_state
    );
endinterface

// File: rtl/relu_rowpair.sv
// ReLU stage that writes a frame into a two-bank line buffer one row pair at a
// time: even rows go to bank 0, odd rows to bank 1. After each pair it raises
// ready_out for two cycles and holds off the source until the pooling stage
// has been busy and gone idle again.
module relu_rowpair #(
    parameter int BD    = 18,
    parameter int WIDTH = 28,
    parameter int ROWS  = 28
) (
    input  logic           clk,
    input  logic           reset,
    relu_rowpair_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROW0    = 3'd1,
        S_ROW1    = 3'd2,
        S_HANDOFF = 3'd3,
        S_WAIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int          PW        = $clog2(ROWS / 2 + 1);
    localparam logic [10:0] LAST_COL  = 11'(WIDTH - 1);
    localparam logic [PW-1:0] LAST_PAIR = PW'(ROWS / 2 - 1);

    state_t        state_q;
    logic [10:0]   col_q;
    logic [PW-1:0] pair_q;
    logic          seen_busy_q;
    logic [1:0]    ho_cnt_q;
    logic          wren0_q;
    logic          wren1_q;
    logic [10:0]   wraddr_q;
    logic [BD-1:0] wd_c0_q;
    logic [BD-1:0] wd_c1_q;
    logic [BD-1:0] wd_c2_q;
    logic          ready_q;
    logic          frame_done_q;
    logic          ovf_q;

    logic          in_row;
    logic          accept;
    logic [BD-1:0] wd_c0_d;
    logic [BD-1:0] wd_c1_d;
    logic [BD-1:0] wd_c2_d;

    // Negative values clamp to zero; non-negative pass through at full width.
    function automatic logic [BD-1:0] relu(input logic [BD-1:0] x);
        return x[BD-1] ? '0 : x;
    endfunction

    // Accept decision and ReLU of the incoming pixel.
    always_comb begin
        in_row  = (state_q == S_ROW0) || (state_q == S_ROW1);
        accept  = bus.vin && in_row;
        wd_c0_d = relu(bus.din_c0);
        wd_c1_d = relu(bus.din_c1);
        wd_c2_d = relu(bus.din_c2);
    end

    // Row-pair sequencer with registered write port and handoff outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            pair_q       <= '0;
            seen_busy_q  <= 1'b0;
            ho_cnt_q     <= '0;
            wren0_q      <= 1'b0;
            wren1_q      <= 1'b0;
            wraddr_q     <= '0;
            wd_c0_q      <= '0;
            wd_c1_q      <= '0;
            wd_c2_q      <= '0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wren0_q      <= 1'b0;
            wren1_q      <= 1'b0;
            frame_done_q <= 1'b0;

            // A pixel offered while stalled is lost; remember it until reset.
            if (bus.vin && !in_row) begin
                ovf_q <= 1'b1;
            end

            if (accept) begin
                wren0_q  <= (state_q == S_ROW0);
                wren1_q  <= (state_q == S_ROW1);
                wraddr_q <= col_q;
                wd_c0_q  <= wd_c0_d;
                wd_c1_q  <= wd_c1_d;
                wd_c2_q  <= wd_c2_d;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q     <= S_ROW0;
                        col_q       <= '0;
                        pair_q      <= '0;
                        seen_busy_q <= 1'b0;
                    end
                end
                S_ROW0: begin
                    if (accept) begin
                        if (col_q == LAST_COL) begin
                            col_q   <= '0;
                            state_q <= S_ROW1;
                        end else begin
                            col_q <= col_q + 11'd1;
                        end
                    end
                end
                S_ROW1: begin
                    if (accept) begin
                        if (col_q == LAST_COL) begin
                            col_q    <= '0;
                            ho_cnt_q <= '0;
                            state_q  <= S_HANDOFF;
                        end else begin
                            col_q <= col_q + 11'd1;
                        end
                    end
                end
                S_HANDOFF: begin
                    // Pooling may already be busy when the pair completes.
                    if (bus.pool_busy) begin
                        seen_busy_q <= 1'b1;
                    end
                    case (ho_cnt_q)
                        2'd0: begin
                            ready_q  <= 1'b1;
                            ho_cnt_q <= 2'd1;
                        end
                        2'd1: begin
                            ho_cnt_q <= 2'd2;
                        end
                        default: begin
                            ready_q  <= 1'b0;
                            ho_cnt_q <= '0;
                            state_q  <= S_WAIT;
                        end
                    endcase
                end
                S_WAIT: begin
                    if (seen_busy_q && !bus.pool_busy) begin
                        seen_busy_q <= 1'b0;
                        pair_q      <= pair_q + 1'b1;
                        if (pair_q == LAST_PAIR) begin
                            state_q      <= S_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= S_ROW0;
                        end
                    end else if (bus.pool_busy) begin
                        seen_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall      = !in_row;
    assign bus.wren0      = wren0_q;
    assign bus.wren1      = wren1_q;
    assign bus.wraddr     = wraddr_q;
    assign bus.wd_c0      = wd_c0_q;
    assign bus.wd_c1      = wd_c1_q;
    assign bus.wd_c2      = wd_c2_q;
    assign bus.ready_out  = ready_q;
    assign bus.frame_done = frame_done_q;
    assign bus.ovf        = ovf_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_relu_rowpair.sv
// Directed bench for relu_rowpair: single row writes and ReLU, pair handoff
// timing, pool handshake, overflow flag, full frame, start in DONE and an
// asynchronous reset in the middle of a row.
module tb_relu_rowpair;
    localparam int BD    = 18;
    localparam int WIDTH = 28;
    localparam int ROWS  = 28;

    localparam logic [31:0] ST_IDLE    = 32'd0;
    localparam logic [31:0] ST_ROW0    = 32'd1;
    localparam logic [31:0] ST_ROW1    = 32'd2;
    localparam logic [31:0] ST_HANDOFF = 32'd3;
    localparam logic [31:0] ST_WAIT    = 32'd4;
    localparam logic [31:0] ST_DONE    = 32'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    relu_rowpair_if #(.BD(BD)) bus();

    relu_rowpair #(.BD(BD), .WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event counters sampled on the falling edge.
    int   ready_pulses = 0;
    int   fd_cycles    = 0;
    int   wren0_cnt    = 0;
    int   wren1_cnt    = 0;
    logic ready_prev   = 1'b0;

    always @(negedge clk) begin
        if (bus.ready_out && !ready_prev) ready_pulses++;
        ready_prev = bus.ready_out;
        if (bus.frame_done) fd_cycles++;
        if (bus.wren0) wren0_cnt++;
        if (bus.wren1) wren1_cnt++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge; inputs and samples happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        ready_pulses = 0;
        fd_cycles    = 0;
        wren0_cnt    = 0;
        wren1_cnt    = 0;
    endtask

    task automatic drive_pixel(input int c0, input int c1, input int c2);
        bus.vin    = 1'b1;
        bus.din_c0 = BD'(c0);
        bus.din_c1 = BD'(c1);
        bus.din_c2 = BD'(c2);
    endtask

    // One row pair with pool handshake; early_busy holds pool_busy high
    // before HANDOFF is entered.
    task automatic run_pair(input bit early_busy, input bit last_pair);
        bit got_ready;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            drive_pixel(k, -k, k + 7);
            if (early_busy && k == 2 * WIDTH - 1) bus.pool_busy = 1'b1;
            tick();
        end
        bus.vin = 1'b0;
        check("pair_last_wren1", {31'd0, bus.wren1}, 32'd1);
        check("pair_last_addr", {21'd0, bus.wraddr}, 32'd27);
        got_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (bus.ready_out) begin
                got_ready = 1'b1;
                break;
            end
        end
        check("pair_ready_seen", {31'd0, got_ready}, 32'd1);
        bus.pool_busy = 1'b1;
        repeat (3) tick();
        check("pair_wait_state", {29'd0, bus.dbg_state}, ST_WAIT);
        bus.pool_busy = 1'b0;
        tick();
        if (last_pair) begin
            check("frame_done_pulse", {31'd0, bus.frame_done}, 32'd1);
            check("frame_state_done", {29'd0, bus.dbg_state}, ST_DONE);
        end else begin
            check("pair_next_row0", {29'd0, bus.dbg_state}, ST_ROW0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.vin       = 1'b0;
        bus.din_c0    = '0;
        bus.din_c1    = '0;
        bus.din_c2    = '0;
        bus.pool_busy = 1'b0;
        repeat (2) tick();

        check("rst_stall", {31'd0, bus.stall}, 32'd1);
        check("rst_wren0", {31'd0, bus.wren0}, 32'd0);
        check("rst_wren1", {31'd0, bus.wren1}, 32'd0);
        check("rst_wraddr", {21'd0, bus.wraddr}, 32'd0);
        check("rst_wd_c0", {14'd0, bus.wd_c0}, 32'd0);
        check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
        check("rst_fdone", {31'd0, bus.frame_done}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_state", {29'd0, bus.dbg_state}, ST_IDLE);

        reset = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_row0", {29'd0, bus.dbg_state}, ST_ROW0);
        check("start_stall", {31'd0, bus.stall}, 32'd0);

        // Row 0: c0 = 5..32, c1 = -3 (clamped), c2 = 0x1FFFF (largest positive).
        clear_counts();
        for (int k = 0; k < WIDTH; k++) begin
            drive_pixel(5 + k, -3, 32'h1FFFF);
            bus.start = (k == 5);   // must be ignored mid-frame
            tick();
            bus.start = 1'b0;
            check("r0_wren0", {31'd0, bus.wren0}, 32'd1);
            check("r0_wren1", {31'd0, bus.wren1}, 32'd0);
            check("r0_addr", {21'd0, bus.wraddr}, 32'(k));
            check("r0_c0", {14'd0, bus.wd_c0}, 32'(5 + k));
            check("r0_c1", {14'd0, bus.wd_c1}, 32'd0);
            check("r0_c2", {14'd0, bus.wd_c2}, 32'h1FFFF);
        end
        check("r0_to_row1", {29'd0, bus.dbg_state}, ST_ROW1);

        // Row 1: c0 = 3k-40 crosses zero at k=14.
        for (int k = 0; k < WIDTH; k++) begin
            v = 3 * k - 40;
            drive_pixel(v, k, -1);
            tick();
            check("r1_wren1", {31'd0, bus.wren1}, 32'd1);
            check("r1_wren0", {31'd0, bus.wren0}, 32'd0);
            check("r1_addr", {21'd0, bus.wraddr}, 32'(k));
            check("r1_c0", {14'd0, bus.wd_c0}, (v < 0) ? 32'd0 : 32'(v));
            check("r1_c2", {14'd0, bus.wd_c2}, 32'd0);
        end
        bus.vin = 1'b0;
        check("last_accept_stall", {31'd0, bus.stall}, 32'd1);
        check("last_accept_ready", {31'd0, bus.ready_out}, 32'd0);
        check("handoff_state", {29'd0, bus.dbg_state}, ST_HANDOFF);
        tick();
        check("ho1_ready", {31'd0, bus.ready_out}, 32'd1);
        check("ho1_wren1", {31'd0, bus.wren1}, 32'd0);
        tick();
        check("ho2_ready", {31'd0, bus.ready_out}, 32'd1);
        tick();
        check("ho3_ready", {31'd0, bus.ready_out}, 32'd0);
        check("ho3_wait", {29'd0, bus.dbg_state}, ST_WAIT);
        check("ho3_stall", {31'd0, bus.stall}, 32'd1);
        check("row_wren0_cnt", 32'(wren0_cnt), 32'd28);
        check("row_wren1_cnt", 32'(wren1_cnt), 32'd28);

        // Pixel offered during WAIT is dropped and flagged.
        drive_pixel(99, 99, 99);
        tick();
        bus.vin = 1'b0;
        check("wait_vin_wren0", {31'd0, bus.wren0}, 32'd0);
        check("wait_vin_wren1", {31'd0, bus.wren1}, 32'd0);
        check("wait_vin_ovf", {31'd0, bus.ovf}, 32'd1);
        repeat (3) tick();
        check("wait_no_busy", {29'd0, bus.dbg_state}, ST_WAIT);

        // Pool busy for 30 cycles, then release.
        bus.pool_busy = 1'b1;
        repeat (30) tick();
        check("busy_stall", {31'd0, bus.stall}, 32'd1);
        bus.pool_busy = 1'b0;
        check("busy_fall_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        check("release_stall", {31'd0, bus.stall}, 32'd0);
        check("release_row0", {29'd0, bus.dbg_state}, ST_ROW0);
        drive_pixel(12, 0, 0);
        tick();
        bus.vin = 1'b0;
        check("next_wren0", {31'd0, bus.wren0}, 32'd1);
        check("next_addr", {21'd0, bus.wraddr}, 32'd0);
        check("ovf_sticky", {31'd0, bus.ovf}, 32'd1);

        // Full frame from a clean reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        clear_counts();
        for (int p = 0; p < ROWS / 2; p++) begin
            run_pair(p == 0, p == ROWS / 2 - 1);
        end
        tick();
        check("fd_one_cycle", {31'd0, bus.frame_done}, 32'd0);
        check("frame_ready_pulses", 32'(ready_pulses), 32'd14);
        check("frame_fd_cycles", 32'(fd_cycles), 32'd1);
        check("frame_wren0", 32'(wren0_cnt), 32'd392);
        check("frame_wren1", 32'(wren1_cnt), 32'd392);
        check("frame_ovf", {31'd0, bus.ovf}, 32'd0);
        check("done_stall", {31'd0, bus.stall}, 32'd1);

        // Start from DONE, then async reset at column 10 of row 1.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_row0", {29'd0, bus.dbg_state}, ST_ROW0);
        for (int k = 0; k < WIDTH + 10; k++) begin
            drive_pixel(k + 1, k + 1, k + 1);
            tick();
        end
        check("pre_rst_wren1", {31'd0, bus.wren1}, 32'd1);
        check("pre_rst_addr", {21'd0, bus.wraddr}, 32'd9);
        drive_pixel(50, 50, 50);
        reset = 1'b1;
        #1;
        check("mid_rst_state", {29'd0, bus.dbg_state}, ST_IDLE);
        check("mid_rst_stall", {31'd0, bus.stall}, 32'd1);
        check("mid_rst_wren1", {31'd0, bus.wren1}, 32'd0);
        check("mid_rst_addr", {21'd0, bus.wraddr}, 32'd0);
        check("mid_rst_wd", {14'd0, bus.wd_c0}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.ready_out}, 32'd0);
        bus.vin = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", {29'd0, bus.dbg_state}, ST_IDLE);
        check("post_rst_wren1", {31'd0, bus.wren1}, 32'd0);
        check("post_rst_ovf", {31'd0, bus.ovf}, 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
